// File: rtl/axi_stream_strip_header.sv
// Drops a descriptor-supplied number of leading bytes from each AXI-Stream packet
// and repacks the remaining payload into full, MSB-aligned output beats.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int STRIP_LEN_WD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [STRIP_LEN_WD-1:0] strip_len,
  output logic                    ready_strip
);

  localparam int CNT_WD = $clog2(DATA_BYTE_WD + 1);
  localparam int SUM_WD = CNT_WD + 1;
  localparam logic [SUM_WD-1:0]       BEAT_BYTES = SUM_WD'(DATA_BYTE_WD);
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL   = '1;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    ALIGN,
    STREAM,
    FLUSH
  } state_t;

  // Keep mask with the top cnt byte lanes set.
  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [SUM_WD-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] k;
    for (int i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (SUM_WD'(i) < cnt);
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] bytes_of(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t                  state, state_nxt;
  logic [STRIP_LEN_WD-1:0] skip_cnt, skip_nxt;
  logic [CNT_WD-1:0]       ofs, ofs_nxt;
  logic [DATA_WD-1:0]      res_data, res_data_nxt;
  logic [CNT_WD-1:0]       res_cnt, res_cnt_nxt;

  logic                    valid_nxt, last_nxt;
  logic [DATA_WD-1:0]      data_nxt;
  logic [DATA_BYTE_WD-1:0] keep_nxt;

  logic                    slot_free, in_fire, strip_fire;
  logic [CNT_WD-1:0]       n_in, n_eff, shift_bytes;
  logic [DATA_WD-1:0]      in_masked, aligned_in, wide_hi, wide_lo;
  logic [2*DATA_WD-1:0]    wide;
  logic [SUM_WD-1:0]       total;
  logic                    emit, emit_last;
  logic [DATA_WD-1:0]      emit_data;
  logic [DATA_BYTE_WD-1:0] emit_keep;

  always_comb begin
    n_in = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) n_in = n_in + CNT_WD'(keep_in[i]);
    in_masked = data_in & bytes_of(keep_in);
  end

  // Byte packer: the residual bytes followed by the new beat's kept bytes.
  // The first kept beat is shifted left by the sub-beat offset; the residual is
  // always empty at that point, so one shifter path serves both ALIGN and STREAM.
  always_comb begin
    if (state == ALIGN) begin
      shift_bytes = ofs;
      n_eff       = (n_in > ofs) ? n_in - ofs : '0;
    end else begin
      shift_bytes = '0;
      n_eff       = n_in;
    end
    aligned_in = in_masked << {shift_bytes, 3'b000};
    wide       = {res_data, {DATA_WD{1'b0}}}
               | ({aligned_in, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
    wide_hi    = wide[2*DATA_WD-1 -: DATA_WD];
    wide_lo    = wide[DATA_WD-1:0];
    total      = SUM_WD'(res_cnt) + SUM_WD'(n_eff);
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    slot_free   = !valid_out || ready_out;
    ready_in    = ((state == SKIP) || (state == ALIGN) || (state == STREAM)) && slot_free;
    ready_strip = (state == IDLE) && slot_free;
    in_fire     = valid_in && ready_in;
    strip_fire  = valid_strip && ready_strip;

    state_nxt    = state;
    skip_nxt     = skip_cnt;
    ofs_nxt      = ofs;
    res_data_nxt = res_data;
    res_cnt_nxt  = res_cnt;
    emit         = 1'b0;
    emit_data    = wide_hi;
    emit_keep    = KEEP_ALL;
    emit_last    = 1'b0;

    case (state)
      IDLE: begin
        if (strip_fire) begin
          skip_nxt     = STRIP_LEN_WD'(strip_len / DATA_BYTE_WD);
          ofs_nxt      = CNT_WD'(strip_len % DATA_BYTE_WD);
          res_data_nxt = '0;
          res_cnt_nxt  = '0;
          state_nxt    = (strip_len >= STRIP_LEN_WD'(DATA_BYTE_WD)) ? SKIP : ALIGN;
        end
      end

      SKIP: begin
        if (in_fire) begin
          skip_nxt = skip_cnt - 1'b1;
          if (last_in)                         state_nxt = IDLE;
          else if (skip_cnt == STRIP_LEN_WD'(1)) state_nxt = ALIGN;
        end
      end

      ALIGN, STREAM: begin
        if (in_fire) begin
          if (last_in) begin
            if (total == '0) begin
              state_nxt = IDLE;
            end else if (total <= BEAT_BYTES) begin
              emit      = 1'b1;
              emit_keep = keep_of(total);
              emit_last = 1'b1;
              state_nxt = IDLE;
            end else begin
              emit         = 1'b1;
              res_data_nxt = wide_lo;
              res_cnt_nxt  = CNT_WD'(total - BEAT_BYTES);
              state_nxt    = FLUSH;
            end
          end else if (total >= BEAT_BYTES) begin
            emit         = 1'b1;
            res_data_nxt = wide_lo;
            res_cnt_nxt  = CNT_WD'(total - BEAT_BYTES);
            state_nxt    = STREAM;
          end else begin
            res_data_nxt = wide_hi;
            res_cnt_nxt  = total[CNT_WD-1:0];
            state_nxt    = STREAM;
          end
        end
      end

      FLUSH: begin
        if (slot_free) begin
          emit        = 1'b1;
          emit_data   = res_data;
          emit_keep   = keep_of(SUM_WD'(res_cnt));
          emit_last   = 1'b1;
          res_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Output register loads only into a free slot, so a stalled beat holds.
    valid_nxt = valid_out;
    data_nxt  = data_out;
    keep_nxt  = keep_out;
    last_nxt  = last_out;
    if (emit) begin
      valid_nxt = 1'b1;
      data_nxt  = emit_data;
      keep_nxt  = emit_keep;
      last_nxt  = emit_last;
    end else if (slot_free) begin
      valid_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      ofs       <= '0;
      res_data  <= '0;
      res_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_nxt;
      ofs       <= ofs_nxt;
      res_data  <= res_data_nxt;
      res_cnt   <= res_cnt_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      keep_out  <= keep_nxt;
      last_out  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header: hand-computed beats checked with
// immediate assertions one cycle after each input beat is accepted.
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_strip = 1'b0;
  logic [3:0]  strip_len = '0;
  logic        ready_strip;

  int total = 0;
  int bad   = 0;

  axi_stream_strip_header dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .keep_in     (keep_in),
    .last_in     (last_in),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .keep_out    (keep_out),
    .last_out    (last_out),
    .ready_out   (ready_out),
    .valid_strip (valid_strip),
    .strip_len   (strip_len),
    .ready_strip (ready_strip)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // Packed view {valid, last, keep, data} of the output register.
  task automatic exp_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    check(tag, {valid_out, last_out, keep_out, data_out}, {1'b1, l, k, d});
  endtask

  task automatic exp_none(input string tag);
    check(tag, valid_out, 1'b0);
  endtask

  task automatic put_desc(input logic [3:0] len);
    int n;
    n = 0;
    @(negedge clk);
    valid_strip = 1'b1;
    strip_len   = len;
    #1;
    while (!ready_strip && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("desc_ready", ready_strip, 1'b1);
    @(posedge clk);
    #1;
    valid_strip = 1'b0;
  endtask

  // Presents one beat at the falling edge; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    #1;
    while (!ready_in && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("beat_ready", ready_in, 1'b1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {valid_out, last_out, keep_out, data_out}, 64'h0);
    check("rst_ready_in", ready_in, 1'b0);
    check("rst_ready_strip", ready_strip, 1'b1);
    rst = 1'b0;

    // strip 3 bytes: offset-only realignment over a six-beat packet
    put_desc(4'd3);
    send(32'hFFEEDDAA, 4'hF, 1'b0); exp_none("t1_b0");
    send(32'hBBCCDDEE, 4'hF, 1'b0); exp_beat("t1_b1", 32'hAABBCCDD, 4'hF, 1'b0);
    send(32'hFF001122, 4'hF, 1'b0); exp_beat("t1_b2", 32'hEEFF0011, 4'hF, 1'b0);
    send(32'h33445566, 4'hF, 1'b0); exp_beat("t1_b3", 32'h22334455, 4'hF, 1'b0);
    send(32'h77889900, 4'hF, 1'b0); exp_beat("t1_b4", 32'h66778899, 4'hF, 1'b0);
    send(32'hAABB0000, 4'hC, 1'b1); exp_beat("t1_b5", 32'h00AABB00, 4'hE, 1'b1);
    check("t1_ready_strip", ready_strip, 1'b1);

    // strip 0: pass-through, masked low bytes read back as zero
    put_desc(4'd0);
    send(32'h11223344, 4'hF, 1'b0); exp_beat("t2_b0", 32'h11223344, 4'hF, 1'b0);
    send(32'h55667788, 4'h8, 1'b1); exp_beat("t2_b1", 32'h55000000, 4'h8, 1'b1);
    @(posedge clk); #1;
    exp_none("t2_idle");

    // strip 4: one whole beat skipped, second beat passes
    put_desc(4'd4);
    send(32'h11223344, 4'hF, 1'b0); exp_none("t3_skip");
    send(32'h55667788, 4'hF, 1'b1); exp_beat("t3_b0", 32'h55667788, 4'hF, 1'b1);

    // strip 6: everything consumed, packet disappears
    put_desc(4'd6);
    send(32'h11223344, 4'hF, 1'b0); exp_none("t4_skip");
    send(32'h55000000, 4'h8, 1'b1); exp_none("t4_drop");
    check("t4_ready_strip", ready_strip, 1'b1);
    put_desc(4'd0);
    send(32'hAABBCCDD, 4'hF, 1'b1); exp_beat("t4_next", 32'hAABBCCDD, 4'hF, 1'b1);

    // strip 1: overflow into FLUSH, with a stalled consumer and an early descriptor
    put_desc(4'd1);
    send(32'h11223344, 4'hF, 1'b0); exp_none("t5_fill");
    send(32'h55667788, 4'hF, 1'b1); exp_beat("t5_b0", 32'h22334455, 4'hF, 1'b0);
    ready_out   = 1'b0;
    valid_strip = 1'b1;
    strip_len   = 4'd0;
    check("t5_flush_ready_in", ready_in, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      exp_beat("t5_hold", 32'h22334455, 4'hF, 1'b0);
      check("t5_ready_in", ready_in, 1'b0);
      check("t5_desc_wait", ready_strip, 1'b0);
    end
    valid_strip = 1'b0;
    ready_out   = 1'b1;
    @(posedge clk); #1;
    exp_beat("t5_flush", 32'h66778800, 4'hE, 1'b1);
    @(posedge clk); #1;
    exp_none("t5_idle");

    // Reset during the third beat of a strip 3 packet
    put_desc(4'd3);
    send(32'hFFEEDDAA, 4'hF, 1'b0); exp_none("t6_b0");
    send(32'hBBCCDDEE, 4'hF, 1'b0); exp_beat("t6_b1", 32'hAABBCCDD, 4'hF, 1'b0);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 32'hFF001122;
    keep_in  = 4'hF;
    last_in  = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_outputs", {valid_out, last_out, keep_out, data_out}, 64'h0);
    check("t6_rst_ready_in", ready_in, 1'b0);
    check("t6_rst_ready_strip", ready_strip, 1'b1);
    rst      = 1'b0;
    valid_in = 1'b0;

    // Fresh packet after reset: two beats, last one spills into FLUSH
    put_desc(4'd3);
    send(32'hFFEEDDAA, 4'hF, 1'b0); exp_none("t7_b0");
    send(32'hBBCCDDEE, 4'hF, 1'b1); exp_beat("t7_b1", 32'hAABBCCDD, 4'hF, 1'b0);
    @(posedge clk); #1;
    exp_beat("t7_flush", 32'hEE000000, 4'h8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
